pio_in_edge_capture: RTL and testbench

Parametrised Avalon-MM slave input port, WIDTH bits wide. The data path per bit is: synchroniser, then optional per-bit debounce filter, then per-bit edge capture. Software can read, mask and clear the capture bits. A maskable irq output serves the SOPC interrupt controller. It replaces the single-bit, read-only, non-interrupting status inputs (touch busy, pen-down, buttons) with one generic block.

---
 rtl/pio_in_edge_capture.sv | 130 +++++++++++++
 tb/tb_pio_in_edge_capture.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_edge_capture.sv
// Generic Avalon-MM input port: synchroniser, optional debounce and edge capture per bit,
// with software-maskable, clearable capture bits and an irq.
module pio_in_edge_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 0,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_TYPE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] interruptmask;
    logic [WIDTH-1:0] edgecapture;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_ok;

    assign unused_ok = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE == 0) begin : g_no_debounce
            assign filt = s;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE + 1);
            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] filt_q;

            // A bit only adopts the synchronised value after disagreeing for DEBOUNCE cycles.
            always_ff @(posedge clk) begin
                if (reset) begin
                    filt_q <= '0;
                    for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
                end else begin
                    for (int b = 0; b < WIDTH; b++) begin
                        if (s[b] == filt_q[b]) begin
                            cnt[b] <= '0;
                        end else if (cnt[b] == CW'(DEBOUNCE - 1)) begin
                            filt_q[b] <= s[b];
                            cnt[b]    <= '0;
                        end else begin
                            cnt[b] <= cnt[b] + CW'(1);
                        end
                    end
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    always_comb begin
        edge_hit = filt & ~prev;
        if (EDGE_TYPE == 1) begin
            edge_hit = ~filt & prev;
        end else if (EDGE_TYPE == 2) begin
            edge_hit = filt ^ prev;
        end
    end

    assign wr_en = chipselect && !write_n;
    assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A fresh edge wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev          <= '0;
            interruptmask <= '0;
            edgecapture   <= '0;
        end else begin
            prev        <= filt;
            edgecapture <= (edgecapture & ~clr) | edge_hit;
            if (wr_en && address == 2'd2) begin
                interruptmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = filt;
            2'd2:    rd_next[WIDTH-1:0] = interruptmask;
            2'd3:    rd_next[WIDTH-1:0] = edgecapture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    generate
        if (IRQ_TYPE == 0) begin : g_level_irq
            assign irq = |(filt & interruptmask);
        end else begin : g_edge_irq
            assign irq = |(edgecapture & interruptmask);
        end
    endgenerate

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Self-checking bench: three parameterisations share one bus and input, checked against
// a behavioural model every cycle, plus a directed vector table and corner sequences.
module tb_pio_in_edge_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // dut0: defaults (rising, edge irq); dut1: debounce 4, any edge, level irq; dut2: falling.
    pio_in_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));
    pio_in_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_TYPE(2), .IRQ_TYPE(0)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));
    pio_in_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0), .EDGE_TYPE(1), .IRQ_TYPE(1)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

    // Behavioural reference: input history delayed two samples, a "disagreement run" per bit
    // that flips the filtered value once it lasts DEBOUNCE cycles, and sticky capture bits.
    logic [7:0]  m_hist0 [3];
    logic [7:0]  m_hist1 [3];
    logic [7:0]  m_filt  [3];
    logic [7:0]  m_prev  [3];
    logic [7:0]  m_mask  [3];
    logic [7:0]  m_cap   [3];
    logic [31:0] m_rd    [3];
    int          m_run   [3][8];
    logic [7:0]  t_f, t_e, t_clr;

    function automatic int deb_of(input int m);
        return (m == 1) ? 4 : 0;
    endfunction

    function automatic int edge_of(input int m);
        return (m == 1) ? 2 : ((m == 2) ? 1 : 0);
    endfunction

    function automatic logic [7:0] seen(input int m);
        return (deb_of(m) == 0) ? m_hist1[m] : m_filt[m];
    endfunction

    function automatic logic model_irq(input int m);
        if (m == 1) return |(seen(m) & m_mask[m]);
        return |(m_cap[m] & m_mask[m]);
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (reset) begin
                m_hist0[m] = '0; m_hist1[m] = '0; m_filt[m] = '0; m_prev[m] = '0;
                m_mask[m]  = '0; m_cap[m]   = '0; m_rd[m]   = '0;
                for (int b = 0; b < 8; b++) m_run[m][b] = 0;
            end else begin
                t_f = seen(m);
                case (edge_of(m))
                    0:       t_e = t_f & ~m_prev[m];
                    1:       t_e = ~t_f & m_prev[m];
                    default: t_e = t_f ^ m_prev[m];
                endcase
                t_clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
                case (address)
                    2'd0:    m_rd[m] = {24'h0, t_f};
                    2'd2:    m_rd[m] = {24'h0, m_mask[m]};
                    2'd3:    m_rd[m] = {24'h0, m_cap[m]};
                    default: m_rd[m] = 32'h0;
                endcase
                m_cap[m] = (m_cap[m] & ~t_clr) | t_e;
                if (chipselect && !write_n && address == 2'd2) m_mask[m] = writedata[7:0];
                m_prev[m] = t_f;
                if (deb_of(m) > 0) begin
                    for (int b = 0; b < 8; b++) begin
                        if (m_hist1[m][b] != m_filt[m][b]) begin
                            m_run[m][b]++;
                            if (m_run[m][b] == deb_of(m)) begin
                                m_filt[m][b] = m_hist1[m][b];
                                m_run[m][b]  = 0;
                            end
                        end else begin
                            m_run[m][b] = 0;
                        end
                    end
                end
                m_hist1[m] = m_hist0[m];
                m_hist0[m] = in_port;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("model_rd0",  rd0,          m_rd[0]);
        checkOutput("model_irq0", {31'h0, irq0}, {31'h0, model_irq(0)});
        checkOutput("model_rd1",  rd1,          m_rd[1]);
        checkOutput("model_irq1", {31'h0, irq1}, {31'h0, model_irq(1)});
        checkOutput("model_rd2",  rd2,          m_rd[2]);
        checkOutput("model_irq2", {31'h0, irq2}, {31'h0, model_irq(2)});
    endtask

    // Drive one cycle's inputs, let the edge happen, then compare on the falling edge.
    task automatic applyStimulus(input logic rst, input logic [7:0] in_val, input logic [1:0] addr,
                                 input logic wr, input logic [7:0] wdata);
        reset      = rst;
        in_port    = in_val;
        address    = addr;
        chipselect = wr;
        write_n    = ~wr;
        writedata  = {24'h0, wdata};
        @(posedge clk);
        @(negedge clk);
        checkModel();
    endtask

    typedef struct {
        logic [7:0]  in_val;
        logic [1:0]  addr;
        logic        wr;
        logic [7:0]  wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [26];
    logic [7:0] cur_in;

    initial begin
        vecs[0]  = '{8'h00, 2'd2, 1'b1, 8'hFF, 32'h00, 1'b0};
        vecs[1]  = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[2]  = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[3]  = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h00, 1'b1};
        vecs[4]  = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h05, 1'b1};
        vecs[5]  = '{8'h05, 2'd0, 1'b0, 8'h00, 32'h05, 1'b1};
        vecs[6]  = '{8'h05, 2'd3, 1'b1, 8'h01, 32'h05, 1'b1};
        vecs[7]  = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h04, 1'b1};
        vecs[8]  = '{8'h05, 2'd3, 1'b1, 8'h04, 32'h04, 1'b0};
        vecs[9]  = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[10] = '{8'h05, 2'd2, 1'b0, 8'h00, 32'hFF, 1'b0};
        vecs[11] = '{8'h05, 2'd2, 1'b1, 8'h00, 32'hFF, 1'b0};
        vecs[12] = '{8'h0D, 2'd3, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[13] = '{8'h0D, 2'd3, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[14] = '{8'h0D, 2'd3, 1'b0, 8'h00, 32'h00, 1'b0};
        vecs[15] = '{8'h0D, 2'd3, 1'b0, 8'h00, 32'h08, 1'b0};
        vecs[16] = '{8'h0D, 2'd2, 1'b1, 8'h08, 32'h00, 1'b1};
        vecs[17] = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h08, 1'b1};
        vecs[18] = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h08, 1'b1};
        vecs[19] = '{8'h05, 2'd3, 1'b0, 8'h00, 32'h08, 1'b1};
        vecs[20] = '{8'h0D, 2'd3, 1'b0, 8'h00, 32'h08, 1'b1};
        vecs[21] = '{8'h0D, 2'd3, 1'b0, 8'h00, 32'h08, 1'b1};
        vecs[22] = '{8'h0D, 2'd3, 1'b1, 8'h08, 32'h08, 1'b1};
        vecs[23] = '{8'h0D, 2'd3, 1'b0, 8'h00, 32'h08, 1'b1};
        vecs[24] = '{8'h0D, 2'd3, 1'b1, 8'h08, 32'h08, 1'b0};
        vecs[25] = '{8'h0D, 2'd3, 1'b0, 8'h00, 32'h00, 1'b0};

        reset = 1'b1; in_port = '0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        @(negedge clk);

        // Reset and idle reads at every address.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h00, 2'(i), 1'b0, 8'h00);
            checkOutput("reset_rd0",  rd0, 32'h0);
            checkOutput("reset_irq0", {31'h0, irq0}, 32'h0);
        end
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b0, 8'h00, 2'(a), 1'b0, 8'h00);
            checkOutput("idle_rd0", rd0, 32'h0);
            checkOutput("idle_rd1", rd1, 32'h0);
        end

        // Directed rising capture, clears, masking and clear/edge collision on dut0.
        for (int i = 0; i < 26; i++) begin
            applyStimulus(1'b0, vecs[i].in_val, vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_rd", i),  rd0, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_irq", i), {31'h0, irq0}, {31'h0, vecs[i].exp_irq});
        end

        // Debounce: a 3-cycle glitch must not reach filt, a steady level arrives after 4 cycles.
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 2'd3, 1'b1, 8'hFF);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, (i < 3) ? 8'h01 : 8'h00, 2'd0, 1'b0, 8'h00);
            checkOutput("deb_glitch_filt", rd1, 32'h0);
        end
        applyStimulus(1'b0, 8'h00, 2'd3, 1'b0, 8'h00);
        checkOutput("deb_glitch_cap", rd1, 32'h0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 8'h01, 2'd0, 1'b0, 8'h00);
            checkOutput($sformatf("deb_hold_k%0d", k), rd1, (k >= 6) ? 32'h1 : 32'h0);
        end
        applyStimulus(1'b0, 8'h01, 2'd3, 1'b0, 8'h00);
        checkOutput("deb_hold_cap", rd1, 32'h1);
        checkOutput("fall_pulse_cap", rd2, 32'h1);

        // Edge types on bit 2: falling-only ignores the rise, any-edge keeps it.
        applyStimulus(1'b0, 8'h01, 2'd3, 1'b1, 8'hFF);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h05, 2'd3, 1'b0, 8'h00);
        checkOutput("fall_rise_ignored", rd2, 32'h0);
        checkOutput("any_rise_captured", rd1, 32'h4);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h01, 2'd3, 1'b0, 8'h00);
        checkOutput("fall_captured", rd2, 32'h4);

        // Mask gating of captured bits.
        applyStimulus(1'b0, 8'h01, 2'd2, 1'b1, 8'h00);
        checkOutput("mask0_irq2", {31'h0, irq2}, 32'h0);
        applyStimulus(1'b0, 8'h01, 2'd2, 1'b1, 8'h04);
        checkOutput("mask4_irq2", {31'h0, irq2}, 32'h1);

        // Level irq on dut1, then reset while the input is still high.
        applyStimulus(1'b0, 8'h00, 2'd2, 1'b1, 8'h02);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h03, 2'd0, 1'b0, 8'h00);
        checkOutput("level_irq1", {31'h0, irq1}, 32'h1);
        applyStimulus(1'b1, 8'h03, 2'd2, 1'b0, 8'h00);
        checkOutput("reset_mid_irq1", {31'h0, irq1}, 32'h0);
        checkOutput("reset_mid_rd1", rd1, 32'h0);
        applyStimulus(1'b1, 8'h00, 2'd2, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 2'd2, 1'b0, 8'h00);
        checkOutput("after_reset_mask", rd1, 32'h0);
        applyStimulus(1'b0, 8'h00, 2'd3, 1'b0, 8'h00);
        checkOutput("after_reset_cap", rd0, 32'h0);

        // Randomised traffic, compared against the model every cycle.
        cur_in = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) cur_in = 8'($urandom);
            applyStimulus(($urandom_range(0, 79) == 0), cur_in, 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
